// File: rtl/motion_integrator.sv
// Frame-locked 2-D position integrator with edge reflection.
// Q10.4 positions advance once per vsync rise, X then Y.
module motion_integrator #(
  parameter int X_MAX  = 608,
  parameter int Y_MAX  = 448,
  parameter int X_INIT = 304,
  parameter int Y_INIT = 224
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        paused,
  input  logic [11:0] step_size,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic        busy,
  output logic        update_done
);

  localparam logic [13:0] LIM_X = 14'(X_MAX * 16);
  localparam logic [13:0] LIM_Y = 14'(Y_MAX * 16);
  localparam logic [13:0] RST_X = 14'(X_INIT * 16);
  localparam logic [13:0] RST_Y = 14'(Y_INIT * 16);

  typedef enum logic [1:0] {
    IDLE,
    UPD_X,
    UPD_Y
  } state_t;

  typedef struct packed {
    logic [13:0] p;
    logic        dir;
    logic        hit;
  } axis_t;

  state_t      state;
  state_t      state_n;
  logic        vsync_q;
  logic        armed;
  logic        rise;
  logic        go;
  logic [7:0]  step_q;
  logic [7:0]  step_clamp;
  logic [13:0] px;
  logic [13:0] py;
  axis_t       adv_x;
  axis_t       adv_y;

  // Overshoot past either end folds back; results are clamped into
  // [0, lim] so tiny limits with large steps cannot wrap.
  function automatic axis_t advance(
    input logic [13:0] p,
    input logic        dir,
    input logic [7:0]  step,
    input logic [13:0] lim
  );
    logic [14:0] s;
    logic [14:0] two_l;
    logic [14:0] d;
    axis_t       r;
    r.p   = p;
    r.dir = dir;
    r.hit = 1'b0;
    s     = {1'b0, p} + {7'd0, step};
    two_l = {lim, 1'b0};
    d     = {7'd0, step} - {1'b0, p};
    if (dir) begin
      if (s > {1'b0, lim}) begin
        r.dir = 1'b0;
        r.hit = 1'b1;
        r.p   = (s > two_l) ? 14'd0 : 14'(two_l - s);
      end else begin
        r.p = 14'(s);
      end
    end else begin
      if ({6'd0, step} > p) begin
        r.dir = 1'b1;
        r.hit = 1'b1;
        r.p   = (d > {1'b0, lim}) ? lim : 14'(d);
      end else begin
        r.p = p - {6'd0, step};
      end
    end
    return r;
  endfunction

  // armed blocks a vsync that was already high when reset released
  assign rise = vsync & ~vsync_q & armed;
  assign go   = rise & ~paused;

  assign step_clamp = (step_size > 12'd255) ? 8'd255 : step_size[7:0];

  always_comb begin
    adv_x = advance(px, dir_x, step_q, LIM_X);
    adv_y = advance(py, dir_y, step_q, LIM_Y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = UPD_X;
      UPD_X:   state_n = UPD_Y;
      UPD_Y:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      armed       <= 1'b0;
      step_q      <= 8'd0;
      px          <= RST_X;
      py          <= RST_Y;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      bounce_x    <= 1'b0;
      bounce_y    <= 1'b0;
      update_done <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      bounce_x    <= 1'b0;
      bounce_y    <= 1'b0;
      update_done <= 1'b0;
      if (!vsync) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (go) step_q <= step_clamp;
        end
        UPD_X: begin
          px       <= adv_x.p;
          dir_x    <= adv_x.dir;
          bounce_x <= adv_x.hit;
        end
        UPD_Y: begin
          py          <= adv_y.p;
          dir_y       <= adv_y.dir;
          bounce_y    <= adv_y.hit;
          update_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pos_x = px[13:4];
  assign pos_y = py[13:4];
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_motion_integrator.sv
// Directed bench for motion_integrator: vector table plus
// hand-written reset, pause, hold and reflection sequences.
module tb_motion_integrator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       paused = 1'b0;
  logic [11:0] step_size = 12'd0;

  logic [9:0] pos_x, pos_y, pos_x2, pos_y2;
  logic dir_x, dir_y, bounce_x, bounce_y, busy, update_done;
  logic dir_x2, dir_y2, bounce_x2, bounce_y2, busy2, update_done2;

  int checks = 0;
  int failures = 0;
  int n_done = 0, n_busy = 0, n_bx = 0, n_by = 0, n_bx2 = 0;

  always #5 clk = ~clk;

  motion_integrator dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused),
    .step_size(step_size), .pos_x(pos_x), .pos_y(pos_y),
    .dir_x(dir_x), .dir_y(dir_y), .bounce_x(bounce_x),
    .bounce_y(bounce_y), .busy(busy), .update_done(update_done)
  );

  motion_integrator #(.X_MAX(305)) dut2 (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused),
    .step_size(step_size), .pos_x(pos_x2), .pos_y(pos_y2),
    .dir_x(dir_x2), .dir_y(dir_y2), .bounce_x(bounce_x2),
    .bounce_y(bounce_y2), .busy(busy2), .update_done(update_done2)
  );

  always @(negedge clk) begin
    if (update_done) n_done++;
    if (busy) n_busy++;
    if (bounce_x) n_bx++;
    if (bounce_y) n_by++;
    if (bounce_x2) n_bx2++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    vsync = 1'b0;
    paused = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic frame();
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst;
    int step;
    int frames;
    int x;
    int y;
    int dx;
    int dy;
    int bx;
    int by;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int d0, b0, bx0, by0, bx20;
    vecs[0] = '{1, 16,   1,  305, 225, 1, 1, 0, 0};
    vecs[1] = '{1, 2,    7,  304, 224, 1, 1, 0, 0};
    vecs[2] = '{0, 2,    1,  305, 225, 1, 1, 0, 0};
    vecs[3] = '{1, 4000, 1,  319, 239, 1, 1, 0, 0};
    vecs[4] = '{1, 0,    1,  304, 224, 1, 1, 0, 0};
    vecs[5] = '{1, 224,  16, 528, 448, 1, 1, 0, 0};
    vecs[6] = '{0, 224,  1,  542, 434, 1, 0, 0, 1};
    vecs[7] = '{1, 255,  20, 593, 353, 0, 0, 1, 1};

    do_reset();
    chk("rst_pos_x", pos_x, 304);
    chk("rst_pos_y", pos_y, 224);
    chk("rst_dir_x", dir_x, 1);
    chk("rst_dir_y", dir_y, 1);
    chk("rst_pulses", {bounce_x, bounce_y, busy, update_done}, 0);

    // single 1.0 px frame, stage by stage
    step_size = 12'd16;
    d0 = n_done;
    b0 = n_busy;
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    chk("e0_busy", busy, 1);
    @(posedge clk); #1;
    chk("e1_pos_x", pos_x, 305);
    chk("e1_pos_y", pos_y, 224);
    chk("e1_done", update_done, 0);
    @(posedge clk); #1;
    chk("e2_pos_y", pos_y, 225);
    chk("e2_done", update_done, 1);
    @(posedge clk); #1;
    chk("e3_done", update_done, 0);
    chk("e3_busy", busy, 0);
    chk("done_count", n_done - d0, 1);
    chk("busy_count", n_busy - b0, 2);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      step_size = 12'(vecs[i].step);
      bx0 = n_bx;
      by0 = n_by;
      for (int f = 0; f < vecs[i].frames; f++) frame();
      chk($sformatf("v%0d_pos_x", i), pos_x, vecs[i].x);
      chk($sformatf("v%0d_pos_y", i), pos_y, vecs[i].y);
      chk($sformatf("v%0d_dir_x", i), dir_x, vecs[i].dx);
      chk($sformatf("v%0d_dir_y", i), dir_y, vecs[i].dy);
      chk($sformatf("v%0d_bnc_x", i), n_bx - bx0, vecs[i].bx);
      chk($sformatf("v%0d_bnc_y", i), n_by - by0, vecs[i].by);
    end

    // paused discards rises; long vsync high counts once
    do_reset();
    step_size = 12'd16;
    paused = 1'b1;
    d0 = n_done;
    b0 = n_busy;
    repeat (3) frame();
    chk("pause_pos_x", pos_x, 304);
    chk("pause_pos_y", pos_y, 224);
    chk("pause_done", n_done - d0, 0);
    chk("pause_busy", n_busy - b0, 0);
    paused = 1'b0;
    d0 = n_done;
    vsync = 1'b1;
    repeat (100) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_done", n_done - d0, 1);
    chk("hold_pos_x", pos_x, 305);

    // reset in UPD_X abandons the update; stale-high vsync ignored
    do_reset();
    step_size = 12'd16;
    d0 = n_done;
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pos_x", pos_x, 304);
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_done", n_done - d0, 0);
    chk("stale_vs_pos_x", pos_x, 304);
    chk("stale_vs_busy", busy, 0);
    vsync = 1'b0;
    step_size = 12'd4000;
    frame();
    chk("clamp_pos_x", pos_x, 319);
    chk("clamp_pos_y", pos_y, 239);

    // narrow X range: reflect at top, walk down, reflect at zero
    do_reset();
    step_size = 12'd24;
    bx20 = n_bx2;
    frame();
    chk("nar1_pos_x", pos_x2, 304);
    chk("nar1_dir_x", dir_x2, 0);
    chk("nar1_bounce", n_bx2 - bx20, 1);
    frame();
    chk("nar2_pos_x", pos_x2, 303);
    chk("nar2_bounce", n_bx2 - bx20, 1);
    step_size = 12'd16;
    bx20 = n_bx2;
    repeat (303) frame();
    chk("zero_pos_x", pos_x2, 0);
    chk("zero_dir_x", dir_x2, 0);
    chk("zero_bounce", n_bx2 - bx20, 0);
    frame();
    chk("low_pos_x", pos_x2, 1);
    chk("low_dir_x", dir_x2, 1);
    chk("low_bounce", n_bx2 - bx20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
